// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: datapath width, register index width and the
// read-source selection used by every register-file read port.
package cpu_pkg;

    localparam int DATA_WIDTH = 17;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Where a register-file read port takes its data from this cycle.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYPASS,
        SRC_STORED
    } read_src_e;

    // The hardwired zero register wins over bypass, and bypass wins over storage.
    function automatic read_src_e read_source(
        input bit    zero_reg,
        input bit    allow_bypass,
        input addr_t addr,
        input logic  write_enable,
        input addr_t write_addr
    );
        if (zero_reg && addr == '0) return SRC_ZERO;
        if (allow_bypass && write_enable && write_addr == addr) return SRC_BYPASS;
        return SRC_STORED;
    endfunction

endpackage

// File: rtl/writeback_register_file_if.sv
// Register-file bus: two read ports, one write port from the write-back mux,
// a debug read port and the committed-write count.
interface writeback_register_file_if
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);

    addr_t                 ReadAddrA;
    data_t                 ReadDataA;
    addr_t                 ReadAddrB;
    data_t                 ReadDataB;
    logic                  WriteEnable;
    addr_t                 WriteAddr;
    data_t                 WriteData;
    addr_t                 DebugAddr;
    data_t                 DebugData;
    logic [CNT_WIDTH-1:0]  WriteCount;

    modport master (
        output ReadAddrA, ReadAddrB, WriteEnable, WriteAddr, WriteData, DebugAddr,
        input  ReadDataA, ReadDataB, DebugData, WriteCount
    );

    modport slave (
        input  ReadAddrA, ReadAddrB, WriteEnable, WriteAddr, WriteData, DebugAddr,
        output ReadDataA, ReadDataB, DebugData, WriteCount
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Inc,
    output logic [WIDTH-1:0] Count
);

    // NOTE: clocked state uses <= so every flop samples pre-edge values, avoiding
    // order-dependent races between always_ff blocks.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc && Count != '1) begin
            Count <= Count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/writeback_register_file.sv
// Architectural register file: two combinational read ports with optional
// same-cycle bypass, one clocked write port, hardwired zero register, debug port.
module writeback_register_file
    import cpu_pkg::*;
#(
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input logic                      Clock,
    input logic                      Reset,
    writeback_register_file_if.slave bus
);

    data_t regs [NUM_REGS];
    logic  commit;

    // Writes to the hardwired zero register are neither stored nor counted.
    assign commit = bus.WriteEnable && !Reset && !(ZERO_REG && bus.WriteAddr == '0);

    // NOTE: the array is plain flops rather than RAM, so it can and must be
    // cleared on reset; reads straight after reset are required to return 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.WriteAddr] <= bus.WriteData;
        end
    end

    function automatic data_t read_port(
        input addr_t addr,
        input bit    allow_bypass,
        input data_t stored,
        input logic  write_enable,
        input addr_t write_addr,
        input data_t write_data
    );
        data_t data;
        // NOTE: the default arm assigns data on every path, so no latch is implied.
        case (read_source(ZERO_REG, allow_bypass, addr, write_enable, write_addr))
            SRC_ZERO:   data = '0;
            SRC_BYPASS: data = write_data;
            default:    data = stored;
        endcase
        return data;
    endfunction

    assign bus.ReadDataA = read_port(bus.ReadAddrA, BYPASS, regs[bus.ReadAddrA],
                                     bus.WriteEnable, bus.WriteAddr, bus.WriteData);
    assign bus.ReadDataB = read_port(bus.ReadAddrB, BYPASS, regs[bus.ReadAddrB],
                                     bus.WriteEnable, bus.WriteAddr, bus.WriteData);
    // Debug always shows the stored value, so it never takes the bypass path.
    assign bus.DebugData = read_port(bus.DebugAddr, 1'b0, regs[bus.DebugAddr],
                                     bus.WriteEnable, bus.WriteAddr, bus.WriteData);

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_write_count (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (commit),
        .Count (bus.WriteCount)
    );

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed + random bench for writeback_register_file: one default instance and one
// with ZERO_REG=0, BYPASS=0, CNT_WIDTH=3, both checked against an array model.
module tb_writeback_register_file;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    writeback_register_file_if #(.CNT_WIDTH(16)) bus_a ();
    writeback_register_file_if #(.CNT_WIDTH(3))  bus_b ();

    writeback_register_file #(
        .ZERO_REG  (1'b1),
        .BYPASS    (1'b1),
        .CNT_WIDTH (16)
    ) dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_a)
    );

    writeback_register_file #(
        .ZERO_REG  (1'b0),
        .BYPASS    (1'b0),
        .CNT_WIDTH (3)
    ) dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_b)
    );

    // Reference state: register contents and committed-write counts.
    logic [16:0] mem_a [8];
    logic [16:0] mem_b [8];
    int          cnt_a;
    int          cnt_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instance A: r0 reads 0; a read of the address being written returns the write data.
    function automatic logic [16:0] ref_a(input logic [2:0] addr, input bit debug);
        if (addr == 3'd0) return 17'd0;
        if (!debug && bus_a.WriteEnable && bus_a.WriteAddr == addr) return bus_a.WriteData;
        return mem_a[addr];
    endfunction

    // Instance B: every register ordinary, no bypass.
    function automatic logic [16:0] ref_b(input logic [2:0] addr);
        return mem_b[addr];
    endfunction

    task automatic idle();
        bus_a.ReadAddrA = '0; bus_a.ReadAddrB = '0; bus_a.DebugAddr = '0;
        bus_a.WriteEnable = 1'b0; bus_a.WriteAddr = '0; bus_a.WriteData = '0;
        bus_b.ReadAddrA = '0; bus_b.ReadAddrB = '0; bus_b.DebugAddr = '0;
        bus_b.WriteEnable = 1'b0; bus_b.WriteAddr = '0; bus_b.WriteData = '0;
    endtask

    // Apply the presented inputs to the model, then advance one clock.
    task automatic cycle();
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (bus_a.WriteEnable && bus_a.WriteAddr != 3'd0) begin
                mem_a[bus_a.WriteAddr] = bus_a.WriteData;
                if (cnt_a < 65535) cnt_a++;
            end
            if (bus_b.WriteEnable) begin
                mem_b[bus_b.WriteAddr] = bus_b.WriteData;
                if (cnt_b < 7) cnt_b++;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [16:0] a, input logic [16:0] b,
                            input logic [16:0] d, input int cnt);
        #1;
        check({tag, ".a.ReadDataA"}, 32'(bus_a.ReadDataA), 32'(a));
        check({tag, ".a.ReadDataB"}, 32'(bus_a.ReadDataB), 32'(b));
        check({tag, ".a.DebugData"}, 32'(bus_a.DebugData), 32'(d));
        check({tag, ".a.WriteCount"}, 32'(bus_a.WriteCount), 32'(cnt));
    endtask

    task automatic expect_b(input string tag, input logic [16:0] a, input logic [16:0] b,
                            input logic [16:0] d, input int cnt);
        #1;
        check({tag, ".b.ReadDataA"}, 32'(bus_b.ReadDataA), 32'(a));
        check({tag, ".b.ReadDataB"}, 32'(bus_b.ReadDataB), 32'(b));
        check({tag, ".b.DebugData"}, 32'(bus_b.DebugData), 32'(d));
        check({tag, ".b.WriteCount"}, 32'(bus_b.WriteCount), 32'(cnt));
    endtask

    task automatic write_a(input logic [2:0] addr, input logic [16:0] data);
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = addr; bus_a.WriteData = data;
        cycle();
        bus_a.WriteEnable = 1'b0;
    endtask

    initial begin
        idle();

        // Reset, then every address reads 0 on all ports of both instances.
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_a.ReadAddrA = 3'(i); bus_a.ReadAddrB = 3'(7 - i); bus_a.DebugAddr = 3'(i);
            bus_b.ReadAddrA = 3'(i); bus_b.ReadAddrB = 3'(7 - i); bus_b.DebugAddr = 3'(i);
            expect_a("reset", 17'd0, 17'd0, 17'd0, 0);
            expect_b("reset", 17'd0, 17'd0, 17'd0, 0);
            cycle();
        end

        // Three consecutive writes, then read them back on A, B and Debug.
        write_a(3'd1, 17'd42);
        write_a(3'd2, 17'd65);
        write_a(3'd3, 17'd85);
        bus_a.ReadAddrA = 3'd1; bus_a.ReadAddrB = 3'd3; bus_a.DebugAddr = 3'd2;
        expect_a("seq_write", 17'd42, 17'd85, 17'd65, 3);

        // Write to r0: hidden on A (zero beats bypass), stored on B where r0 is ordinary.
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 3'd0; bus_a.WriteData = 17'h1FFFF;
        bus_a.ReadAddrA = 3'd0; bus_a.ReadAddrB = 3'd1; bus_a.DebugAddr = 3'd0;
        bus_b.WriteEnable = 1'b1; bus_b.WriteAddr = 3'd0; bus_b.WriteData = 17'h1FFFF;
        bus_b.ReadAddrA = 3'd0; bus_b.ReadAddrB = 3'd0; bus_b.DebugAddr = 3'd0;
        expect_a("r0_same_cycle", 17'd0, 17'd42, 17'd0, 3);
        cycle();
        bus_a.WriteEnable = 1'b0; bus_b.WriteEnable = 1'b0;
        expect_a("r0_after", 17'd0, 17'd42, 17'd0, 3);
        expect_b("r0_after", 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1);

        // Same-cycle write/read of r4: bypassed on A, stored value on B and Debug.
        bus_b.WriteEnable = 1'b1; bus_b.WriteAddr = 3'd4; bus_b.WriteData = 17'd7;
        write_a(3'd4, 17'd7);
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 3'd4; bus_a.WriteData = 17'd99;
        bus_a.ReadAddrA = 3'd4; bus_a.ReadAddrB = 3'd4; bus_a.DebugAddr = 3'd4;
        bus_b.WriteEnable = 1'b1; bus_b.WriteAddr = 3'd4; bus_b.WriteData = 17'd99;
        bus_b.ReadAddrA = 3'd4; bus_b.ReadAddrB = 3'd4; bus_b.DebugAddr = 3'd4;
        expect_a("bypass", 17'd99, 17'd99, 17'd7, 4);
        expect_b("no_bypass", 17'd7, 17'd7, 17'd7, 2);
        cycle();
        bus_a.WriteEnable = 1'b0; bus_b.WriteEnable = 1'b0;
        expect_a("bypass_after", 17'd99, 17'd99, 17'd99, 5);
        expect_b("no_bypass_after", 17'd99, 17'd99, 17'd99, 3);

        // Reset during a write: the write is dropped and the count clears.
        write_a(3'd5, 17'd10);
        bus_a.DebugAddr = 3'd5;
        expect_a("pre_reset", 17'd99, 17'd99, 17'd10, 6);
        Reset = 1'b1;
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 3'd5; bus_a.WriteData = 17'd123;
        cycle();
        Reset = 1'b0;
        bus_a.WriteEnable = 1'b0;
        bus_a.ReadAddrA = 3'd5; bus_a.ReadAddrB = 3'd4;
        expect_a("reset_mid_write", 17'd0, 17'd0, 17'd0, 0);
        expect_b("reset_mid_write", 17'd0, 17'd0, 17'd0, 0);

        // 3-bit counter: nine committed writes count 1..7, then hold at 7.
        for (int k = 1; k <= 9; k++) begin
            bus_b.WriteEnable = 1'b1; bus_b.WriteAddr = 3'(k % 8); bus_b.WriteData = 17'(k * 3);
            cycle();
            bus_b.WriteEnable = 1'b0;
            bus_b.ReadAddrA = 3'(k % 8); bus_b.ReadAddrB = 3'(k % 8); bus_b.DebugAddr = 3'(k % 8);
            expect_b("saturate", 17'(k * 3), 17'(k * 3), 17'(k * 3), (k < 7) ? k : 7);
        end

        // Random traffic on both instances, including occasional resets.
        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 31) == 0);
            bus_a.ReadAddrA = 3'($urandom()); bus_a.ReadAddrB = 3'($urandom());
            bus_a.DebugAddr = 3'($urandom()); bus_a.WriteEnable = 1'($urandom());
            bus_a.WriteAddr = 3'($urandom()); bus_a.WriteData = 17'($urandom());
            bus_b.ReadAddrA = 3'($urandom()); bus_b.ReadAddrB = 3'($urandom());
            bus_b.DebugAddr = 3'($urandom()); bus_b.WriteEnable = 1'($urandom());
            bus_b.WriteAddr = 3'($urandom()); bus_b.WriteData = 17'($urandom());
            expect_a("random", ref_a(bus_a.ReadAddrA, 1'b0), ref_a(bus_a.ReadAddrB, 1'b0),
                     ref_a(bus_a.DebugAddr, 1'b1), cnt_a);
            expect_b("random", ref_b(bus_b.ReadAddrA), ref_b(bus_b.ReadAddrB),
                     ref_b(bus_b.DebugAddr), cnt_b);
            cycle();
        end
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
